if_fetch_queue: RTL and testbench

IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

---
 rtl/if_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 49 ++++
 rtl/if_fetch_queue.sv | 116 +++++++++++
 tb/tb_if_fetch_queue.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared definitions for the instruction fetch front end: redirect select
// encodings and the default address/instruction widths.
package if_pkg;

  typedef enum logic [1:0] {
    PCSRC_SEQ = 2'b00,
    PCSRC_J   = 2'b01,
    PCSRC_I   = 2'b10,
    PCSRC_RET = 2'b11
  } pc_src_e;

  localparam int ADDR_W_DEF  = 16;
  localparam int INSTR_W_DEF = 16;

endpackage

// File: rtl/fetch_fifo.sv
// Circular FIFO holding fetched {npc, instruction} records; flush empties it
// in one cycle and takes priority over push and pop.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       push_data,
  output logic [WIDTH-1:0]       head_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = DEPTH[CW-1:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rptr;
  logic [PW-1:0]    wptr;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == '0);
  assign do_push   = push && (count != FULL_CNT);
  assign do_pop    = pop && !empty;
  assign head_data = mem[rptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count <= count + {{(CW-1){1'b0}}, do_push} - {{(CW-1){1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !flush && do_push) mem[wptr] <= push_data;
  end

endmodule

// File: rtl/if_fetch_queue.sv
// Fetch front end: PC sequencing, redirect/kill handling with epoch-tagged
// in-flight responses, and a decoupling queue towards decode.
module if_fetch_queue
  import if_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                INSTR_W  = INSTR_W_DEF,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             pc_src,
  input  logic [ADDR_W-1:0]      j_target,
  input  logic [ADDR_W-1:0]      i_target,
  input  logic [ADDR_W-1:0]      ret_target,
  input  logic                   kill,
  output logic                   imem_req,
  output logic [ADDR_W-1:0]      imem_addr,
  input  logic [INSTR_W-1:0]     imem_rdata,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_W-1:0]     out_instr,
  output logic [ADDR_W-1:0]      out_npc,
  output logic [$clog2(DEPTH):0] out_count
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int QW = ADDR_W + INSTR_W;
  localparam logic [CW:0] DEPTH_LIM = DEPTH[CW:0];

  pc_src_e           pc_sel;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] target;
  logic              redirect;
  logic              flush;
  logic              epoch;
  logic              inflight_valid;
  logic              inflight_epoch;
  logic [ADDR_W-1:0] inflight_npc;
  logic [CW:0]       pending;
  logic              push;
  logic              pop;
  logic              empty;
  logic [QW-1:0]     head_data;
  logic [ADDR_W-1:0] head_npc;
  logic [INSTR_W-1:0] head_instr;
  logic [ADDR_W-1:0] last_npc;
  logic [INSTR_W-1:0] last_instr;

  assign pc_sel   = pc_src_e'(pc_src);
  assign redirect = (pc_sel != PCSRC_SEQ);
  assign flush    = redirect || kill;

  // Count the outstanding fetch so a response always has a free slot to land in.
  assign pending   = {1'b0, out_count} + {{CW{1'b0}}, inflight_valid};
  assign imem_req  = rst_n && !flush && (pending < DEPTH_LIM);
  assign imem_addr = pc;

  assign push = inflight_valid && (inflight_epoch == epoch) && !flush;
  assign pop  = out_valid && out_ready && !flush;

  always_comb begin
    target = pc;
    case (pc_sel)
      PCSRC_J:   target = j_target;
      PCSRC_I:   target = i_target;
      PCSRC_RET: target = ret_target;
      default:   target = pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc             <= RESET_PC;
      epoch          <= 1'b0;
      inflight_valid <= 1'b0;
      inflight_epoch <= 1'b0;
      inflight_npc   <= '0;
      last_npc       <= '0;
      last_instr     <= '0;
    end else begin
      if (redirect)      pc <= target;
      else if (imem_req) pc <= pc + 1'b1;
      if (flush) epoch <= ~epoch;
      inflight_valid <= imem_req;
      inflight_epoch <= epoch;
      inflight_npc   <= pc + 1'b1;
      // Remember the head so the outputs stay stable once the queue drains.
      if (!empty) begin
        last_npc   <= head_npc;
        last_instr <= head_instr;
      end
    end
  end

  fetch_fifo #(
    .WIDTH (QW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (push),
    .pop       (pop),
    .push_data ({inflight_npc, imem_rdata}),
    .head_data (head_data),
    .count     (out_count),
    .empty     (empty)
  );

  assign {head_npc, head_instr} = head_data;
  assign out_valid = !empty;
  assign out_instr = empty ? last_instr : head_instr;
  assign out_npc   = empty ? last_npc : head_npc;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: a vector table for streaming/backpressure/
// redirect, plus hand sequences for kill, combined redirect+kill+pop and 4-bit wrap.
module tb_if_fetch_queue;
  import if_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  pc_src;
  logic [15:0] j_target, i_target, ret_target;
  logic        kill;
  logic        out_ready;

  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        out_valid;
  logic [15:0] out_instr;
  logic [15:0] out_npc;
  logic [2:0]  out_count;

  logic        s_req;
  logic [3:0]  s_addr;
  logic [15:0] s_rdata;
  logic        s_valid;
  logic [15:0] s_instr;
  logic [3:0]  s_npc;
  logic [2:0]  s_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        rst_n;
    logic [1:0]  src;
    logic        kill;
    logic        ready;
    logic        req;
    logic [15:0] addr;
    logic        valid;
    logic [15:0] npc;
    logic [2:0]  count;
  } vec_t;

  vec_t vecs[$];

  if_fetch_queue dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc_src     (pc_src),
    .j_target   (j_target),
    .i_target   (i_target),
    .ret_target (ret_target),
    .kill       (kill),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_npc    (out_npc),
    .out_count  (out_count)
  );

  if_fetch_queue #(
    .ADDR_W   (4),
    .INSTR_W  (16),
    .DEPTH    (4),
    .RESET_PC (4'd13)
  ) dut_small (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc_src     (pc_src),
    .j_target   (j_target[3:0]),
    .i_target   (i_target[3:0]),
    .ret_target (ret_target[3:0]),
    .kill       (kill),
    .imem_req   (s_req),
    .imem_addr  (s_addr),
    .imem_rdata (s_rdata),
    .out_valid  (s_valid),
    .out_ready  (out_ready),
    .out_instr  (s_instr),
    .out_npc    (s_npc),
    .out_count  (s_count)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [15:0] instr_of(input logic [15:0] a);
    return a + 16'h1000;
  endfunction

  // Instruction memories answer one cycle after the address is presented.
  always @(posedge clk) begin
    imem_rdata <= instr_of(imem_addr);
    s_rdata    <= instr_of({12'h000, s_addr});
  end

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [1:0] src, input logic k, input logic rdy);
    @(posedge clk);
    #1;
    rst_n     = r;
    pc_src    = src;
    kill      = k;
    out_ready = rdy;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic req, input logic [15:0] addr,
                             input logic valid, input logic [15:0] npc, input logic [2:0] cnt);
    checkVal({tag, " req"},   32'(imem_req),  32'(req));
    checkVal({tag, " addr"},  32'(imem_addr), 32'(addr));
    checkVal({tag, " valid"}, 32'(out_valid), 32'(valid));
    checkVal({tag, " npc"},   32'(out_npc),   32'(npc));
    checkVal({tag, " count"}, 32'(out_count), 32'(cnt));
    if (valid) checkVal({tag, " instr"}, 32'(out_instr), 32'(instr_of(npc - 16'd1)));
  endtask

  task automatic checkSmall(input string tag, input logic req, input logic [3:0] addr,
                            input logic valid, input logic [3:0] npc, input logic [2:0] cnt);
    logic [3:0] src_addr;
    src_addr = npc - 4'd1;
    checkVal({tag, " req"},   32'(s_req),   32'(req));
    checkVal({tag, " addr"},  32'(s_addr),  32'(addr));
    checkVal({tag, " valid"}, 32'(s_valid), 32'(valid));
    checkVal({tag, " npc"},   32'(s_npc),   32'(npc));
    checkVal({tag, " count"}, 32'(s_count), 32'(cnt));
    if (valid) checkVal({tag, " instr"}, 32'(s_instr), 32'(instr_of({12'h000, src_addr})));
  endtask

  task automatic resetDut();
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b0, PCSRC_SEQ, 1'b0, 1'b1);
      checkVal("reset req", 32'(imem_req), 32'd0);
      checkVal("reset small req", 32'(s_req), 32'd0);
      if (k == 1) begin
        checkVal("reset addr", 32'(imem_addr), 32'd0);
        checkVal("reset count", 32'(out_count), 32'd0);
        checkVal("reset valid", 32'(out_valid), 32'd0);
        checkVal("reset small addr", 32'(s_addr), 32'd13);
      end
    end
  endtask

  task automatic addVec(input logic r, input logic [1:0] src, input logic k, input logic rdy,
                        input logic req, input logic [15:0] addr, input logic valid,
                        input logic [15:0] npc, input logic [2:0] cnt);
    vec_t v;
    v.rst_n = r;   v.src  = src;  v.kill  = k;     v.ready = rdy;
    v.req   = req; v.addr = addr; v.valid = valid; v.npc   = npc; v.count = cnt;
    vecs.push_back(v);
  endtask

  initial begin
    rst_n      = 1'b0;
    pc_src     = PCSRC_SEQ;
    kill       = 1'b0;
    out_ready  = 1'b1;
    j_target   = 16'd8;
    i_target   = 16'd10;
    ret_target = 16'd12;

    // rst src kill rdy | req addr valid npc count
    addVec(1, 0, 0, 1,  1,  0, 0,  0, 0);
    addVec(1, 0, 0, 1,  1,  1, 0,  0, 0);
    addVec(1, 0, 0, 1,  1,  2, 1,  1, 1);
    addVec(1, 0, 0, 1,  1,  3, 1,  2, 1);
    addVec(1, 0, 0, 1,  1,  4, 1,  3, 1);
    addVec(1, 0, 0, 0,  1,  5, 1,  4, 1);
    addVec(1, 0, 0, 0,  1,  6, 1,  4, 2);
    addVec(1, 0, 0, 0,  0,  7, 1,  4, 3);
    addVec(1, 0, 0, 0,  0,  7, 1,  4, 4);
    addVec(1, 0, 0, 0,  0,  7, 1,  4, 4);
    addVec(1, 0, 0, 1,  0,  7, 1,  4, 4);
    addVec(1, 0, 0, 1,  1,  7, 1,  5, 3);
    addVec(1, 0, 0, 1,  1,  8, 1,  6, 2);
    addVec(1, 0, 0, 1,  1,  9, 1,  7, 2);
    addVec(1, 0, 0, 1,  1, 10, 1,  8, 2);
    addVec(1, 1, 0, 1,  0, 11, 1,  9, 2);
    addVec(1, 0, 0, 1,  1,  8, 0,  9, 0);
    addVec(1, 0, 0, 1,  1,  9, 0,  9, 0);
    addVec(1, 0, 0, 1,  1, 10, 1,  9, 1);
    addVec(0, 0, 0, 1,  0, 11, 1, 10, 1);
    addVec(0, 0, 0, 1,  0,  0, 0,  0, 0);
    addVec(1, 0, 0, 1,  1,  0, 0,  0, 0);
    addVec(1, 0, 0, 1,  1,  1, 0,  0, 0);
    addVec(1, 0, 0, 1,  1,  2, 1,  1, 1);

    resetDut();
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst_n, vecs[i].src, vecs[i].kill, vecs[i].ready);
      checkOutput($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr, vecs[i].valid,
                  vecs[i].npc, vecs[i].count);
    end

    // Build PC=5 with three queued entries and a fetch in flight, then kill.
    resetDut();
    applyStimulus(1, PCSRC_SEQ, 0, 0); checkOutput("kill t0", 1, 0, 0, 0, 0);
    applyStimulus(1, PCSRC_SEQ, 0, 0); checkOutput("kill t1", 1, 1, 0, 0, 0);
    applyStimulus(1, PCSRC_SEQ, 0, 0); checkOutput("kill t2", 1, 2, 1, 1, 1);
    applyStimulus(1, PCSRC_SEQ, 0, 0); checkOutput("kill t3", 1, 3, 1, 1, 2);
    applyStimulus(1, PCSRC_SEQ, 0, 0); checkOutput("kill t4", 0, 4, 1, 1, 3);
    applyStimulus(1, PCSRC_SEQ, 0, 1); checkOutput("kill t5", 0, 4, 1, 1, 4);
    applyStimulus(1, PCSRC_SEQ, 0, 0); checkOutput("kill t6", 1, 4, 1, 2, 3);
    applyStimulus(1, PCSRC_SEQ, 1, 0); checkOutput("kill t7", 0, 5, 1, 2, 3);
    applyStimulus(1, PCSRC_SEQ, 0, 1); checkOutput("kill t8", 1, 5, 0, 2, 0);
    applyStimulus(1, PCSRC_SEQ, 0, 1); checkOutput("kill t9", 1, 6, 0, 2, 0);
    applyStimulus(1, PCSRC_SEQ, 0, 1); checkOutput("kill t10", 1, 7, 1, 6, 1);

    // Return redirect together with kill and a pop, then an I-type redirect.
    applyStimulus(1, PCSRC_RET, 1, 1); checkOutput("redir t11", 0, 8, 1, 7, 1);
    applyStimulus(1, PCSRC_SEQ, 0, 1); checkOutput("redir t12", 1, 12, 0, 7, 0);
    applyStimulus(1, PCSRC_SEQ, 0, 1); checkOutput("redir t13", 1, 13, 0, 7, 0);
    applyStimulus(1, PCSRC_SEQ, 0, 1); checkOutput("redir t14", 1, 14, 1, 13, 1);
    applyStimulus(1, PCSRC_I, 0, 1);   checkOutput("redir t15", 0, 15, 1, 14, 1);
    applyStimulus(1, PCSRC_SEQ, 0, 1); checkOutput("redir t16", 1, 10, 0, 14, 0);
    applyStimulus(1, PCSRC_SEQ, 0, 1); checkOutput("redir t17", 1, 11, 0, 14, 0);
    applyStimulus(1, PCSRC_SEQ, 0, 1); checkOutput("redir t18", 1, 12, 1, 11, 1);

    // 4-bit instance starting at 13: address and npc wrap, then mid-stream reset.
    resetDut();
    applyStimulus(1, PCSRC_SEQ, 0, 1); checkSmall("wrap u0", 1, 13, 0, 0, 0);
    applyStimulus(1, PCSRC_SEQ, 0, 1); checkSmall("wrap u1", 1, 14, 0, 0, 0);
    applyStimulus(1, PCSRC_SEQ, 0, 1); checkSmall("wrap u2", 1, 15, 1, 14, 1);
    applyStimulus(1, PCSRC_SEQ, 0, 1); checkSmall("wrap u3", 1, 0, 1, 15, 1);
    applyStimulus(1, PCSRC_SEQ, 0, 1); checkSmall("wrap u4", 1, 1, 1, 0, 1);
    applyStimulus(0, PCSRC_SEQ, 0, 1); checkSmall("wrap u5", 0, 2, 1, 1, 1);
    applyStimulus(1, PCSRC_SEQ, 0, 1); checkSmall("wrap u6", 1, 13, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
